// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath width, bubble encoding and fetch FSM states.
package mips_pkg;

  localparam int unsigned PC_W = 32;

  // sll $0,$0,0
  localparam logic [PC_W-1:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Combinational next-PC selection: exception vector > redirect target > hold > PC+4.
// FETCH_ALIGN_CHECK_EN: a misaligned redirect is vectored to EXC_VECTOR instead of taken.
module fetch_pc_gen
  import mips_pkg::*;
#(
  parameter logic [PC_W-1:0] EXC_VECTOR = 32'h0000_0040
) (
  input  logic [PC_W-1:0] i_pc,
  input  logic            i_exc_valid,
  input  logic            i_redirect_valid,
  input  logic [PC_W-1:0] i_redirect_pc,
  input  logic            i_hold,
  output logic [PC_W-1:0] o_next_pc,
  output logic [PC_W-1:0] o_pc_plus4,
  output logic            o_misalign
);

  logic [PC_W-1:0] w_target;

  // Plain modulo-2^32 add: 32'hFFFF_FFFC wraps to zero.
  assign o_pc_plus4 = i_pc + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
  assign o_misalign = i_redirect_valid && (i_redirect_pc[1:0] != 2'b00);
  assign w_target   = i_redirect_pc;
`else
  assign o_misalign = 1'b0;
  assign w_target   = {i_redirect_pc[PC_W-1:2], 2'b00};
`endif

  // NOTE: every output gets a default first so this block can never infer a latch.
  always_comb begin
    o_next_pc = o_pc_plus4;
    if (i_exc_valid || o_misalign) begin
      o_next_pc = EXC_VECTOR;
    end else if (i_redirect_valid) begin
      o_next_pc = w_target;
    end else if (i_hold) begin
      o_next_pc = i_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch: PC register, boot/run/halt FSM and the IF/ID pipeline register.
// Optional misaligned-redirect trap is enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [PC_W-1:0] EXC_VECTOR = 32'h0000_0040,
  parameter logic [PC_W-1:0] NOP_INSTR  = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] imem_pc,
  input  logic [PC_W-1:0] imem_instruction,
  input  logic            stall,
  input  logic            flush,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            exc_valid,
  input  logic            halt_req,
  output logic [PC_W-1:0] if_id_instr,
  output logic [PC_W-1:0] if_id_pc4,
  output logic            if_id_valid,
  output logic            fetch_exc
);

  fetch_state_t    r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_if_id_instr;
  logic [PC_W-1:0] r_if_id_pc4;
  logic            r_if_id_valid;
  logic            r_fetch_exc;

  logic [PC_W-1:0] w_next_pc;
  logic [PC_W-1:0] w_pc_plus4;
  logic            w_misalign;
  logic            w_frozen;
  logic            w_squash;

  // A halt request takes effect on the edge it is first seen, not one cycle later.
  assign w_frozen = (r_state == S_BOOT) || (r_state == S_HALT) ||
                    ((r_state == S_RUN) && halt_req);
  assign w_squash = flush || exc_valid || redirect_valid;

  fetch_pc_gen #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_pc_gen (
    .i_pc            (r_pc),
    .i_exc_valid     (exc_valid),
    .i_redirect_valid(redirect_valid),
    .i_redirect_pc   (redirect_pc),
    .i_hold          (stall || w_frozen),
    .o_next_pc       (w_next_pc),
    .o_pc_plus4      (w_pc_plus4),
    .o_misalign      (w_misalign)
  );

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_BOOT;
      r_pc          <= RESET_PC;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_pc4   <= '0;
      r_if_id_valid <= 1'b0;
      r_fetch_exc   <= 1'b0;
    end else begin
      r_pc        <= w_next_pc;
      r_fetch_exc <= w_misalign && !exc_valid;

      unique case (r_state)
        S_BOOT: r_state <= S_RUN;
        S_RUN:  if (halt_req && !exc_valid && !redirect_valid) r_state <= S_HALT;
        S_HALT: if (!halt_req || exc_valid) r_state <= S_RUN;
        default: r_state <= S_BOOT;
      endcase

      if (w_squash || (w_frozen && !stall)) begin
        r_if_id_instr <= NOP_INSTR;
        r_if_id_pc4   <= '0;
        r_if_id_valid <= 1'b0;
      end else if (!stall) begin
        r_if_id_instr <= imem_instruction;
        r_if_id_pc4   <= w_pc_plus4;
        r_if_id_valid <= 1'b1;
      end
    end
  end

  assign imem_pc     = r_pc;
  assign if_id_instr = r_if_id_instr;
  assign if_id_pc4   = r_if_id_pc4;
  assign if_id_valid = r_if_id_valid;
  assign fetch_exc   = r_fetch_exc;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: driver queues hand-computed per-edge expectations,
// a monitor pops and compares them after every rising edge.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] imem_pc;
  logic [31:0] imem_instruction;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        exc_valid;
  logic        halt_req;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        fetch_exc;

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] pc4;
    logic        fexc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   step_idx = 0;

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .imem_pc         (imem_pc),
    .imem_instruction(imem_instruction),
    .stall           (stall),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .exc_valid       (exc_valid),
    .halt_req        (halt_req),
    .if_id_instr     (if_id_instr),
    .if_id_pc4       (if_id_pc4),
    .if_id_valid     (if_id_valid),
    .fetch_exc       (fetch_exc)
  );

  // Instruction memory: an addi-style word tagged with its own address.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return 32'h2000_0000 ^ a;
  endfunction

  assign imem_instruction = imem_word(imem_pc);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, req);
    end
  endtask

  task automatic step(input logic rst, input logic st, input logic fl, input logic rv,
                      input logic [31:0] rpc, input logic ex, input logic hl,
                      input logic [31:0] e_pc, input logic e_v, input logic [31:0] e_pc4,
                      input logic e_fx);
    exp_t e;
    @(negedge clk);
    reset          = rst;
    stall          = st;
    flush          = fl;
    redirect_valid = rv;
    redirect_pc    = rpc;
    exc_valid      = ex;
    halt_req       = hl;
    e.idx   = step_idx;
    e.pc    = e_pc;
    e.valid = e_v;
    e.pc4   = e_pc4;
    e.fexc  = e_fx;
    exp_q.push_back(e);
    step_idx++;
  endtask

  // Monitor: the DUT presents new fetch-stage state after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("imem_pc", e.idx, imem_pc, e.pc);
        check("if_id_valid", e.idx, {31'd0, if_id_valid}, {31'd0, e.valid});
        check("if_id_pc4", e.idx, if_id_pc4, e.pc4);
        check("if_id_instr", e.idx, if_id_instr,
              e.valid ? imem_word(e.pc4 - 32'd4) : 32'h0000_0000);
        check("fetch_exc", e.idx, {31'd0, fetch_exc}, {31'd0, e.fexc});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; exc_valid = 1'b0; halt_req = 1'b0;

    //    rst st fl rv rpc            ex hl   pc             v  pc4            fx
    // Reset two cycles, boot cycle, then sequential fetch.
    step(1, 0, 0, 0, 32'h0,        0, 0,  32'h0,         0, 32'h0,         0);
    step(1, 0, 0, 0, 32'h0,        0, 0,  32'h0,         0, 32'h0,         0);
    step(0, 0, 0, 0, 32'h0,        0, 0,  32'h0,         0, 32'h0,         0);
    step(0, 0, 0, 0, 32'h0,        0, 0,  32'h4,         1, 32'h4,         0);
    step(0, 0, 0, 0, 32'h0,        0, 0,  32'h8,         1, 32'h8,         0);
    step(0, 0, 0, 0, 32'h0,        0, 0,  32'hC,         1, 32'hC,         0);
    // Stall three cycles at PC=12.
    step(0, 1, 0, 0, 32'h0,        0, 0,  32'hC,         1, 32'hC,         0);
    step(0, 1, 0, 0, 32'h0,        0, 0,  32'hC,         1, 32'hC,         0);
    step(0, 1, 0, 0, 32'h0,        0, 0,  32'hC,         1, 32'hC,         0);
    step(0, 0, 0, 0, 32'h0,        0, 0,  32'h10,        1, 32'h10,        0);
    step(0, 0, 0, 0, 32'h0,        0, 0,  32'h14,        1, 32'h14,        0);
    // Halt at PC=20; release costs one more held cycle while FSM leaves S_HALT.
    step(0, 0, 0, 0, 32'h0,        0, 1,  32'h14,        0, 32'h0,         0);
    step(0, 0, 0, 0, 32'h0,        0, 1,  32'h14,        0, 32'h0,         0);
    step(0, 0, 0, 0, 32'h0,        0, 0,  32'h14,        0, 32'h0,         0);
    step(0, 0, 0, 0, 32'h0,        0, 0,  32'h18,        1, 32'h18,        0);
    step(0, 0, 0, 0, 32'h0,        0, 0,  32'h1C,        1, 32'h1C,        0);
    step(0, 0, 0, 0, 32'h0,        0, 0,  32'h20,        1, 32'h20,        0);
    step(0, 0, 0, 0, 32'h0,        0, 0,  32'h24,        1, 32'h24,        0);
    // Jump back to 0 at PC=36: one bubble, then word@0.
    step(0, 0, 0, 1, 32'h0,        0, 0,  32'h0,         0, 32'h0,         0);
    step(0, 0, 0, 0, 32'h0,        0, 0,  32'h4,         1, 32'h4,         0);
    // Flush alone squashes IF/ID but PC advances.
    step(0, 0, 1, 0, 32'h0,        0, 0,  32'h8,         0, 32'h0,         0);
    step(0, 0, 0, 0, 32'h0,        0, 0,  32'hC,         1, 32'hC,         0);
    // Stall and flush together: PC holds, IF/ID bubbles.
    step(0, 1, 1, 0, 32'h0,        0, 0,  32'hC,         0, 32'h0,         0);
    step(0, 0, 0, 0, 32'h0,        0, 0,  32'h10,        1, 32'h10,        0);
    // Exception beats redirect and stall.
    step(0, 1, 0, 1, 32'h80,       1, 0,  32'h40,        0, 32'h0,         0);
    step(0, 0, 0, 0, 32'h0,        0, 0,  32'h44,        1, 32'h44,        0);
    // Redirect overrides stall.
    step(0, 1, 0, 1, 32'h100,      0, 0,  32'h100,       0, 32'h0,         0);
    step(0, 0, 0, 0, 32'h0,        0, 0,  32'h104,       1, 32'h104,       0);
    // Misaligned redirect target.
`ifdef FETCH_ALIGN_CHECK_EN
    step(0, 0, 0, 1, 32'h2A,       0, 0,  32'h40,        0, 32'h0,         1);
    step(0, 0, 0, 0, 32'h0,        0, 0,  32'h44,        1, 32'h44,        0);
`else
    step(0, 0, 0, 1, 32'h2A,       0, 0,  32'h28,        0, 32'h0,         0);
    step(0, 0, 0, 0, 32'h0,        0, 0,  32'h2C,        1, 32'h2C,        0);
`endif
    // PC+4 wraps modulo 2^32.
    step(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 0, 32'h0,         0);
    step(0, 0, 0, 0, 32'h0,        0, 0,  32'h0,         1, 32'h0,         0);
    step(0, 0, 0, 0, 32'h0,        0, 0,  32'h4,         1, 32'h4,         0);
    // Reset mid-operation re-enters the boot cycle.
    step(1, 0, 0, 0, 32'h0,        0, 0,  32'h0,         0, 32'h0,         0);
    step(0, 0, 0, 0, 32'h0,        0, 0,  32'h0,         0, 32'h0,         0);
    step(0, 0, 0, 0, 32'h0,        0, 0,  32'h4,         1, 32'h4,         0);
    // Exception releases a halted fetch.
    step(0, 0, 0, 0, 32'h0,        0, 1,  32'h4,         0, 32'h0,         0);
    step(0, 0, 0, 0, 32'h0,        1, 1,  32'h40,        0, 32'h0,         0);
    step(0, 0, 0, 0, 32'h0,        0, 0,  32'h44,        1, 32'h44,        0);

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drain", step_idx, exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
